divide_arbiter: RTL and testbench
=================================

# divide_arbiter

Shares one FIFO-interfaced `divide_two_inputs` divider between `NUM_CH` requester channels (e.g. per-audio-channel normalisation stages). Each channel supplies dividend/divisor FIFOs and owns a quotient FIFO. The block round-robin-selects a ready channel and stages its operands in a holding register. It presents that register to the divider as a pair of FIFOs, tracks channel ownership in an in-order tag queue, and steers each returned quotient to the owning channel's output FIFO.

## Interface
- `NUM_CH`, 2, number of requester channels (2..8); channel i uses bits [32i+31:32i] of packed buses
- `TAG_DEPTH`, 4, max outstanding operations: hold register plus tag queue (1..8)
- `TAG_W`, max(1,$clog2(NUM_CH)), tag width (derived)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `ch_a_empty` / `ch_b_empty`  in  NUM_CH  per-channel dividend / divisor FIFO empty
- `ch_a_dout` / `ch_b_dout`  in  32*NUM_CH  per-channel signed dividend / divisor
- `ch_a_rd_en` / `ch_b_rd_en`  out  NUM_CH  per-channel pops; always asserted together, at most one bit set
- `ch_q_full`  in  NUM_CH  per-channel quotient FIFO full
- `ch_q_wr_en`  out  NUM_CH  per-channel quotient write, one-hot or zero
- `ch_q_din`  out  32  quotient, broadcast to all channels
- `div_a_empty` / `div_b_empty`  out  1  divider-facing operand FIFO empties
- `div_a_dout` / `div_b_dout`  out  32  held dividend / divisor
- `div_a_rd_en` / `div_b_rd_en`  in  1  divider operand pops
- `div_q_full`  out  1  divider-facing result FIFO full
- `div_q_wr_en`  in  1  divider result write
- `div_q_din`  in  32  divider quotient
- `err`  out  1  sticky protocol-error flag

## Operation
- Issue FSM, two states:
  - IDLE: hold register empty.
  - HOLD: operands held, `div_a_empty`=`div_b_empty`=0.
- Channel i is eligible when `!ch_a_empty[i] && !ch_b_empty[i]`.
- IDLE->HOLD when some channel is eligible and (tag count < `TAG_DEPTH`). Same cycle, combinationally:
  - Grant the first eligible channel scanning from `rr_ptr` upward with wrap.
  - Assert its `ch_a_rd_en`/`ch_b_rd_en`.
  - Capture `dout`s into the hold register at the edge; store the grant as `hold_tag`.
  - `rr_ptr` <= grant+1 mod NUM_CH.
- HOLD->IDLE when `div_a_rd_en && div_b_rd_en`: push `hold_tag` into the tag queue. No new grant in that cycle.
- Occupancy: outstanding = tag count + hold valid ≤ `TAG_DEPTH`.
- Return path is combinational:
  - `div_q_full` = tag queue empty OR `ch_q_full[head_tag]`.
  - On `div_q_wr_en && !div_q_full`: `ch_q_wr_en[head_tag]`=1, `ch_q_din`=`div_q_din`, pop the tag queue.
- Tag queue push and pop in the same cycle: count unchanged, both take effect.
- Operands and quotient pass unmodified. Sign handling belongs to the divider.
- `err` sets, and holds until reset, on any of:
  - `div_a_rd_en` != `div_b_rd_en`;
  - a divider rd_en while in IDLE;
  - `div_q_wr_en` while `div_q_full`.
- The offending action is otherwise ignored: no push, pop or write.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, tag queue empty, `err`=0.
  - All `ch_*_rd_en`/`ch_q_wr_en`=0, `ch_q_din`=0.
  - `div_a_empty`=`div_b_empty`=1, `div_*_dout`=0, `div_q_full`=1.
- Reset mid-operation discards the hold register and all tags. Results the divider returns afterwards see `div_q_full`=1.
- Request to divider: channel eligible at cycle N gives pop at N and divider-visible operands at N+1.
- Result to channel: zero added latency. `ch_q_wr_en` is asserted in the same cycle as the accepted `div_q_wr_en`.
- Back-to-back issue: a new grant comes no earlier than the cycle after the divider pops the hold register.
- Channel FIFO `dout` must be valid while empty=0 (first-word-fall-through).

## Test plan
- Reset: all outputs at the listed reset values; `div_q_full`=1, `div_a_empty`=1, `err`=0.
- Single op: ch0 supplies A=100, B=7, divider model returns 14 -> `ch0_q_wr_en` pulses once with `ch_q_din`=14. Also ch1 supplies A=-100, B=7 -> `ch1_q_wr_en` with -14.
- Round-robin fairness: both channels continuously eligible for 8 ops -> grant order 0,1,0,1,... Results land on channels in issue order.
- Backpressure: result tagged for ch1 while `ch_q_full[1]`=1 -> `div_q_full`=1 and no write. Deassert full -> single write of the held quotient to ch1.
- Depth limit: `TAG_DEPTH`=1, divider slow to return -> no second grant until the first result is written; then the grant occurs the next eligible cycle.
- Error and reset: divider asserts `div_a_rd_en` alone -> `err`=1, hold retained. Assert reset mid-HOLD -> state IDLE, tags cleared, `err`=0.

Source files
------------

// File: rtl/divide_arbiter.sv
// Shares one FIFO-interfaced divider between NUM_CH requester channels: round-robin
// issue through a one-entry hold register, in-order tag queue steers quotients home.
module divide_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_a_empty,
  input  logic [NUM_CH-1:0]     ch_b_empty,
  input  logic [32*NUM_CH-1:0]  ch_a_dout,
  input  logic [32*NUM_CH-1:0]  ch_b_dout,
  output logic [NUM_CH-1:0]     ch_a_rd_en,
  output logic [NUM_CH-1:0]     ch_b_rd_en,
  input  logic [NUM_CH-1:0]     ch_q_full,
  output logic [NUM_CH-1:0]     ch_q_wr_en,
  output logic [31:0]           ch_q_din,
  output logic                  div_a_empty,
  output logic                  div_b_empty,
  output logic [31:0]           div_a_dout,
  output logic [31:0]           div_b_dout,
  input  logic                  div_a_rd_en,
  input  logic                  div_b_rd_en,
  output logic                  div_q_full,
  input  logic                  div_q_wr_en,
  input  logic [31:0]           div_q_din,
  output logic                  err
);

  localparam int TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]        state;
  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  hold_tag;
  logic [31:0]       hold_a;
  logic [31:0]       hold_b;
  logic [TAG_W-1:0]  grant_idx;
  logic [TAG_W-1:0]  grant_next;
  logic              grant_valid;

  logic [TAG_W-1:0]  tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  tag_cnt;
  logic [TAG_W-1:0]  head_tag;

  logic [NUM_CH-1:0] eligible;
  logic              issue;
  logic              div_pop;
  logic              q_accept;
  logic              rd_err;
  logic              wr_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign eligible = ~ch_a_empty & ~ch_b_empty;

  // Round-robin scan: descending loop so the eligible channel closest to rr_ptr wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_ptr) + k) % NUM_CH]) begin
        grant_valid = 1'b1;
        grant_idx   = TAG_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  assign grant_next = (grant_idx == TAG_W'(NUM_CH - 1)) ? '0 : grant_idx + TAG_W'(1);

  assign issue    = !reset && (state == IDLE) && grant_valid && (tag_cnt < CNT_W'(TAG_DEPTH));
  assign div_pop  = (state == HOLD) && div_a_rd_en && div_b_rd_en;
  assign head_tag = tag_mem[rd_ptr];

  assign div_q_full = (tag_cnt == '0) || ch_q_full[head_tag];
  assign q_accept   = div_q_wr_en && !div_q_full;
  assign rd_err     = (div_a_rd_en != div_b_rd_en) ||
                      ((state == IDLE) && (div_a_rd_en || div_b_rd_en));
  assign wr_err     = div_q_wr_en && div_q_full;

  always_comb begin
    ch_a_rd_en = '0;
    ch_q_wr_en = '0;
    if (issue)    ch_a_rd_en[grant_idx] = 1'b1;
    if (q_accept) ch_q_wr_en[head_tag]  = 1'b1;
  end

  assign ch_b_rd_en  = ch_a_rd_en;
  assign ch_q_din    = q_accept ? div_q_din : '0;
  assign div_a_empty = (state != HOLD);
  assign div_b_empty = (state != HOLD);
  assign div_a_dout  = hold_a;
  assign div_b_dout  = hold_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_tag <= '0;
      hold_a   <= '0;
      hold_b   <= '0;
      err      <= 1'b0;
    end else begin
      if (issue) begin
        state    <= HOLD;
        hold_a   <= ch_a_dout[32*int'(grant_idx) +: 32];
        hold_b   <= ch_b_dout[32*int'(grant_idx) +: 32];
        hold_tag <= grant_idx;
        rr_ptr   <= grant_next;
      end else if (div_pop) begin
        state <= IDLE;
      end
      err <= err | rd_err | wr_err;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (div_pop)  wr_ptr <= ptr_inc(wr_ptr);
      if (q_accept) rd_ptr <= ptr_inc(rd_ptr);
      case ({div_pop, q_accept})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // NOTE: tag storage has no reset; entries are only read while tag_cnt says they are valid.
  always_ff @(posedge clock) begin
    if (div_pop) tag_mem[wr_ptr] <= hold_tag;
  end

endmodule

// File: tb/tb_divide_arbiter.sv
// Randomized bench for divide_arbiter: queue-based channel/divider models and a
// transaction-level reference of grant order, tag ownership and error rules.
module tb_divide_arbiter;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    ch_a_empty, ch_b_empty, ch_a_rd_en, ch_b_rd_en;
  logic [32*NUM_CH-1:0] ch_a_dout, ch_b_dout;
  logic [NUM_CH-1:0]    ch_q_full, ch_q_wr_en;
  logic [31:0]          ch_q_din;
  logic                 div_a_empty, div_b_empty;
  logic [31:0]          div_a_dout, div_b_dout;
  logic                 div_a_rd_en, div_b_rd_en;
  logic                 div_q_full, div_q_wr_en;
  logic [31:0]          div_q_din;
  logic                 err;

  divide_arbiter #(.NUM_CH(NUM_CH), .TAG_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ch_a_empty(ch_a_empty), .ch_b_empty(ch_b_empty),
    .ch_a_dout(ch_a_dout), .ch_b_dout(ch_b_dout),
    .ch_a_rd_en(ch_a_rd_en), .ch_b_rd_en(ch_b_rd_en),
    .ch_q_full(ch_q_full), .ch_q_wr_en(ch_q_wr_en), .ch_q_din(ch_q_din),
    .div_a_empty(div_a_empty), .div_b_empty(div_b_empty),
    .div_a_dout(div_a_dout), .div_b_dout(div_b_dout),
    .div_a_rd_en(div_a_rd_en), .div_b_rd_en(div_b_rd_en),
    .div_q_full(div_q_full), .div_q_wr_en(div_q_wr_en), .div_q_din(div_q_din),
    .err(err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Channel source FIFOs, divider in-flight results, per-channel expected quotients.
  int a_src[NUM_CH][$];
  int b_src[NUM_CH][$];
  int exp_res[NUM_CH][$];
  int pend_q[$];
  int m_tags[$];
  int grant_log[$];
  bit m_hold;
  int m_hold_a, m_hold_b, m_hold_tag;
  int m_rr;
  bit m_err;
  int wr_cnt[NUM_CH];
  int last_q[NUM_CH];

  int rd_pct, ret_pct, full_pct;
  bit rd_block, ret_block, bad_a_only;
  bit [NUM_CH-1:0] force_full;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_op(input int ch, input int a, input int b);
    a_src[ch].push_back(a);
    b_src[ch].push_back(b);
  endtask

  function automatic int rand_divisor();
    int b;
    b = int'($urandom_range(1000, 2));
    return ($urandom_range(1, 0) == 1) ? -b : b;
  endfunction

  function automatic int pending_total();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) n += a_src[i].size() + exp_res[i].size();
    return n;
  endfunction

  // One clock: drive at the falling edge, check mid-cycle, advance the model for the next rising edge.
  task automatic cycle();
    int  g;
    int  tag;
    bit  exp_qfull, exp_wr, rd;
    @(negedge clock);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_a_empty[i] = (a_src[i].size() == 0);
      ch_b_empty[i] = (b_src[i].size() == 0);
      ch_a_dout[32*i +: 32] = (a_src[i].size() > 0) ? a_src[i][0] : 0;
      ch_b_dout[32*i +: 32] = (b_src[i].size() > 0) ? b_src[i][0] : 0;
      ch_q_full[i] = force_full[i] || (int'($urandom_range(99, 0)) < full_pct);
    end
    if (bad_a_only) begin
      div_a_rd_en = 1'b1;
      div_b_rd_en = 1'b0;
    end else begin
      rd = m_hold && !rd_block && (int'($urandom_range(99, 0)) < rd_pct);
      div_a_rd_en = rd;
      div_b_rd_en = rd;
    end
    exp_qfull   = (m_tags.size() == 0) || ch_q_full[m_tags[0]];
    div_q_wr_en = !ret_block && (pend_q.size() > 0) && !exp_qfull &&
                  (int'($urandom_range(99, 0)) < ret_pct);
    div_q_din   = (pend_q.size() > 0) ? pend_q[0] : 0;
    #2;

    g = -1;
    if (!m_hold && m_tags.size() < DEPTH) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c = (m_rr + k) % NUM_CH;
        if (g < 0 && a_src[c].size() > 0 && b_src[c].size() > 0) g = c;
      end
    end
    check("ch_a_rd_en", ch_a_rd_en, (g >= 0) ? (1 << g) : 0);
    check("ch_b_rd_en", ch_b_rd_en, (g >= 0) ? (1 << g) : 0);
    check("div_a_empty", div_a_empty, !m_hold);
    check("div_b_empty", div_b_empty, !m_hold);
    if (m_hold) begin
      check("div_a_dout", $signed(div_a_dout), m_hold_a);
      check("div_b_dout", $signed(div_b_dout), m_hold_b);
    end
    check("div_q_full", div_q_full, exp_qfull);
    exp_wr = div_q_wr_en && !exp_qfull;
    check("ch_q_wr_en", ch_q_wr_en, exp_wr ? (1 << m_tags[0]) : 0);
    if (exp_wr) check("q_data", $signed(ch_q_din), exp_res[m_tags[0]][0]);
    check("err", err, m_err);

    if ((div_a_rd_en != div_b_rd_en) || ((div_a_rd_en || div_b_rd_en) && !m_hold) ||
        (div_q_wr_en && exp_qfull))
      m_err = 1'b1;
    if (exp_wr) begin
      tag = m_tags.pop_front();
      wr_cnt[tag]++;
      last_q[tag] = pend_q.pop_front();
      void'(exp_res[tag].pop_front());
    end
    if (m_hold && div_a_rd_en && div_b_rd_en) begin
      m_tags.push_back(m_hold_tag);
      pend_q.push_back(m_hold_a / m_hold_b);
      m_hold = 1'b0;
    end
    if (g >= 0) begin
      m_hold     = 1'b1;
      m_hold_a   = a_src[g].pop_front();
      m_hold_b   = b_src[g].pop_front();
      m_hold_tag = g;
      m_rr       = (g + 1) % NUM_CH;
      grant_log.push_back(g);
      exp_res[g].push_back(m_hold_a / m_hold_b);
    end
  endtask

  // Asserts reset with channels showing data: no pop may leak out while reset is high.
  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    ch_a_empty  = '0;
    ch_b_empty  = '0;
    ch_q_full   = '0;
    div_a_rd_en = 1'b0;
    div_b_rd_en = 1'b0;
    div_q_wr_en = 1'b1;
    div_q_din   = 32'd77;
    #1;
    check("rst_ch_a_rd_en", ch_a_rd_en, 0);
    check("rst_ch_b_rd_en", ch_b_rd_en, 0);
    check("rst_ch_q_wr_en", ch_q_wr_en, 0);
    check("rst_ch_q_din", ch_q_din, 0);
    check("rst_div_a_empty", div_a_empty, 1);
    check("rst_div_b_empty", div_b_empty, 1);
    check("rst_div_a_dout", div_a_dout, 0);
    check("rst_div_b_dout", div_b_dout, 0);
    check("rst_div_q_full", div_q_full, 1);
    check("rst_err", err, 0);
    div_q_wr_en = 1'b0;
    ch_a_empty  = '1;
    ch_b_empty  = '1;
    m_hold = 1'b0;
    m_rr   = 0;
    m_err  = 1'b0;
    m_tags.delete();
    pend_q.delete();
    for (int i = 0; i < NUM_CH; i++) exp_res[i].delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_writes(input int ch, input int target, input string tag);
    int n = 0;
    while (wr_cnt[ch] < target && n < 200) begin
      cycle();
      n++;
    end
    check(tag, wr_cnt[ch], target);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rd_pct = 100; ret_pct = 100; full_pct = 0; force_full = '0;
    rd_block = 1'b0; ret_block = 1'b0;
    while (pending_total() > 0 && n < 2000) begin
      cycle();
      n++;
    end
    check(tag, pending_total(), 0);
  endtask

  initial begin
    int base, ngrant;
    reset = 1'b1;
    ch_a_empty = '1; ch_b_empty = '1; ch_a_dout = '0; ch_b_dout = '0;
    ch_q_full = '0; div_a_rd_en = 1'b0; div_b_rd_en = 1'b0;
    div_q_wr_en = 1'b0; div_q_din = '0;
    rd_pct = 100; ret_pct = 100; full_pct = 0;
    rd_block = 1'b0; ret_block = 1'b0; bad_a_only = 1'b0; force_full = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_cnt[i] = 0;
      last_q[i] = 0;
    end
    do_reset();

    // Single operations on each channel.
    push_op(0, 100, 7);
    wait_writes(0, 1, "single_ch0_writes");
    check("single_ch0_q", last_q[0], 14);
    push_op(1, -100, 7);
    wait_writes(1, 1, "single_ch1_writes");
    check("single_ch1_q", last_q[1], -14);

    // Both channels continuously eligible: grants alternate starting at ch0.
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      push_op(0, int'($urandom), rand_divisor());
      push_op(1, int'($urandom), rand_divisor());
    end
    drain("rr_drain");
    check("rr_count", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check($sformatf("rr_grant%0d", k), grant_log[k], k % 2);

    // Backpressure on ch1's quotient FIFO holds the result in the divider.
    base = wr_cnt[1];
    force_full = 2'b10;
    push_op(1, 50, -5);
    for (int k = 0; k < 12; k++) cycle();
    check("bp_no_write", wr_cnt[1], base);
    check("bp_q_full", div_q_full, 1);
    force_full = '0;
    wait_writes(1, base + 1, "bp_release_write");
    check("bp_q", last_q[1], -10);

    // Depth limit: divider never returns, so issue stops at DEPTH outstanding.
    grant_log.delete();
    ret_block = 1'b1;
    for (int k = 0; k < 6; k++) push_op(0, int'($urandom), rand_divisor());
    for (int k = 0; k < 30; k++) cycle();
    ngrant = grant_log.size();
    check("depth_grants", ngrant, DEPTH);
    check("depth_idle", div_a_empty, 1);
    drain("depth_drain");

    // Randomized traffic with random divider timing and channel backpressure.
    rd_pct = 60; ret_pct = 50; full_pct = 30;
    for (int n = 0; n < 600; n++) begin
      int c = int'($urandom_range(NUM_CH - 1, 0));
      if ($urandom_range(2, 0) != 0 && a_src[c].size() < 4)
        push_op(c, int'($urandom), rand_divisor());
      cycle();
    end
    drain("random_drain");

    // Protocol error while holding operands, then reset mid-HOLD.
    push_op(0, 9, 3);
    rd_block = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    bad_a_only = 1'b1;
    cycle();
    bad_a_only = 1'b0;
    cycle();
    check("err_set", err, 1);
    check("err_hold_kept", div_a_empty, 0);
    check("err_hold_a", $signed(div_a_dout), 9);
    do_reset();
    rd_block = 1'b0;
    push_op(1, 21, 7);
    base = wr_cnt[1];
    wait_writes(1, base + 1, "post_reset_write");
    check("post_reset_q", last_q[1], 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
